// File: rtl/imm_decode_ctrl.sv
// imm_decode_ctrl: valid/ready sequencer around a combinational immediate unit.
// Decodes the opcode, drives the IU for one cycle, then holds the captured result for downstream.
module imm_decode_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   output logic [24:0]      iu_imm,
   output logic [2:0]       iu_src,
   input  logic [31:0]      iu_ext,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [CNT_W-1:0] dec_count
);

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   typedef struct packed {
      logic       illegal;
      logic       no_imm;
      logic [2:0] src;
   } dec_t;

   state_t state;
   logic   no_imm;
   logic   illegal;
   logic   accept;
   logic   handoff;
   dec_t   dec;

   function automatic dec_t decode_op(input logic [6:0] op);
      dec_t d;
      d.illegal = 1'b0;
      d.no_imm  = 1'b0;
      d.src     = 3'b000;
      case (op)
         7'b0010011, 7'b0000011, 7'b1100111: d.src = 3'b000;
         7'b0100011:                         d.src = 3'b001;
         7'b1100011:                         d.src = 3'b010;
         7'b0110111, 7'b0010111:             d.src = 3'b101;
         7'b1101111:                         d.src = 3'b110;
         7'b0110011:                         d.no_imm  = 1'b1;
         default:                            d.illegal = 1'b1;
      endcase
      return d;
   endfunction

   // A new instruction may enter when idle, or when the held result leaves this same cycle.
   assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
   assign accept   = in_valid && in_ready;
   assign handoff  = out_valid && out_ready;
   assign dec      = decode_op(instr[6:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         iu_imm      <= '0;
         iu_src      <= '0;
         no_imm      <= 1'b0;
         illegal     <= 1'b0;
         out_valid   <= 1'b0;
         out_imm     <= '0;
         out_fmt     <= '0;
         out_illegal <= 1'b0;
         dec_count   <= '0;
      end else begin
         // IU inputs only move on an accept, so they are stable for the whole ISSUE cycle.
         if (accept) begin
            iu_imm  <= instr[31:7];
            iu_src  <= dec.src;
            no_imm  <= dec.no_imm;
            illegal <= dec.illegal;
         end

         if (handoff)
            dec_count <= dec_count + CNT_W'(1);

         case (state)
            IDLE: begin
               if (accept)
                  state <= ISSUE;
            end
            ISSUE: begin
               out_imm     <= (no_imm || illegal) ? 32'd0 : iu_ext;
               out_fmt     <= iu_src;
               out_illegal <= illegal;
               out_valid   <= 1'b1;
               state       <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= in_valid ? ISSUE : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Bench for imm_decode_ctrl: two DUTs (CNT_W=16 and CNT_W=2) share stimulus, each with its own IU,
// checked each cycle against a result-queue model plus directed literal cases.
module tb_imm_decode_ctrl;

   typedef struct packed {
      logic        ill;
      logic [2:0]  fmt;
      logic [31:0] imm;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] instr;
   logic        out_ready;

   logic        in_ready, in_ready2;
   logic [24:0] iu_imm, iu_imm2;
   logic [2:0]  iu_src, iu_src2;
   logic [31:0] iu_ext, iu_ext2;
   logic        out_valid, out_valid2;
   logic [31:0] out_imm, out_imm2;
   logic [2:0]  out_fmt, out_fmt2;
   logic        out_illegal, out_illegal2;
   logic [15:0] dec_count;
   logic [1:0]  dec_count2;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   // Immediate unit placed between iu_imm/iu_src and iu_ext (iu_imm holds instr[31:7]).
   function automatic logic [31:0] iu_fn(input logic [24:0] imm, input logic [2:0] src);
      logic [31:0] r;
      case (src)
         3'b000:  r = {{20{imm[24]}}, imm[24:13]};
         3'b001:  r = {{20{imm[24]}}, imm[24:18], imm[4:0]};
         3'b010:  r = {{19{imm[24]}}, imm[24], imm[0], imm[23:18], imm[4:1], 1'b0};
         3'b101:  r = {imm[24:5], 12'd0};
         3'b110:  r = {{11{imm[24]}}, imm[24], imm[12:5], imm[13], imm[23:14], 1'b0};
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   assign iu_ext  = iu_fn(iu_imm, iu_src);
   assign iu_ext2 = iu_fn(iu_imm2, iu_src2);

   imm_decode_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
      .iu_imm(iu_imm), .iu_src(iu_src), .iu_ext(iu_ext), .out_valid(out_valid),
      .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
      .out_illegal(out_illegal), .dec_count(dec_count)
   );

   imm_decode_ctrl #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .instr(instr),
      .iu_imm(iu_imm2), .iu_src(iu_src2), .iu_ext(iu_ext2), .out_valid(out_valid2),
      .out_ready(out_ready), .out_imm(out_imm2), .out_fmt(out_fmt2),
      .out_illegal(out_illegal2), .dec_count(dec_count2)
   );

   // Reference result from the whole instruction word using signed arithmetic on fields.
   function automatic res_t ref_result(input logic [31:0] ins);
      res_t r;
      int   s;
      s     = signed'(ins);
      r.ill = 1'b0;
      r.fmt = 3'd0;
      r.imm = 32'd0;
      case (ins[6:0])
         7'h13, 7'h03, 7'h67: r.imm = 32'(s >>> 20);
         7'h23: begin
            r.fmt = 3'd1;
            r.imm = 32'((s >>> 25) * 32 + int'(ins[11:7]));
         end
         7'h63: begin
            r.fmt = 3'd2;
            r.imm = 32'((s >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                        + int'(ins[11:8]) * 2);
         end
         7'h37, 7'h17: begin
            r.fmt = 3'd5;
            r.imm = ins & 32'hFFFFF000;
         end
         7'h6F: begin
            r.fmt = 3'd6;
            r.imm = 32'((s >>> 31) * (1 << 20) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                        + int'(ins[30:21]) * 2);
         end
         7'h33: r.imm = 32'd0;
         default: r.ill = 1'b1;
      endcase
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Model: one instruction may be in flight (pending) and one result may be on display.
   logic m_pend, m_show, m_acc, m_ho;
   res_t m_pend_res, m_cur;
   int   m_count;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pend  = 1'b0;
         m_show  = 1'b0;
         m_count = 0;
      end else begin
         m_ho  = m_show && out_ready;
         m_acc = in_valid && !m_pend && (!m_show || out_ready);
         if (m_ho) begin
            m_count++;
            m_show = 1'b0;
         end
         if (m_pend) begin
            m_show = 1'b1;
            m_cur  = m_pend_res;
            m_pend = 1'b0;
         end
         if (m_acc) begin
            m_pend     = 1'b1;
            m_pend_res = ref_result(instr);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("in_ready", 32'(in_ready), 32'(!m_pend && (!m_show || out_ready)));
         chk("out_valid", 32'(out_valid), 32'(m_show));
         chk("out_valid2", 32'(out_valid2), 32'(m_show));
         if (m_show) begin
            chk("out_imm", out_imm, m_cur.imm);
            chk("out_fmt", 32'(out_fmt), 32'(m_cur.fmt));
            chk("out_illegal", 32'(out_illegal), 32'(m_cur.ill));
         end
         chk("dec_count", 32'(dec_count), 32'(m_count & 16'hFFFF));
         chk("dec_count2", 32'(dec_count2), 32'(m_count & 3));
      end
   end

   // Entered at #1 after a posedge with the DUT idle; leaves it idle at #1 after a posedge.
   task automatic run_one(input string name, input logic [31:0] ins, input logic [31:0] e_imm,
                          input logic [2:0] e_fmt, input logic e_ill);
      in_valid  = 1'b1;
      instr     = ins;
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk({name, "_lat_valid0"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk({name, "_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_imm"}, out_imm, e_imm);
      chk({name, "_fmt"}, 32'(out_fmt), 32'(e_fmt));
      chk({name, "_ill"}, 32'(out_illegal), 32'(e_ill));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   logic [6:0]  ops [0:10];
   logic [31:0] rnd;
   logic [31:0] held_imm;
   int          cnt_before;

   initial begin
      ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h0B};
      rst       = 1'b1;
      in_valid  = 1'b0;
      instr     = 32'd0;
      out_ready = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_imm", out_imm, 32'd0);
      chk("rst_dec_count", 32'(dec_count), 32'd0);
      chk("rst_iu_imm", 32'(iu_imm), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      run_one("addi", 32'hFFF00093, 32'hFFFFFFFF, 3'b000, 1'b0);
      run_one("sw",   32'h00A12423, 32'h00000008, 3'b001, 1'b0);
      run_one("beq",  32'hFE000EE3, 32'hFFFFFFFC, 3'b010, 1'b0);
      run_one("lui",  32'h123452B7, 32'h12345000, 3'b101, 1'b0);
      run_one("jal",  32'h0080006F, 32'h00000008, 3'b110, 1'b0);
      run_one("ill",  32'h0000007F, 32'h00000000, 3'b000, 1'b1);
      run_one("rtype", 32'h002081B3, 32'h00000000, 3'b000, 1'b0);

      // Stall in HOLD, then a back-to-back handoff plus accept.
      in_valid = 1'b1;
      instr    = 32'hFFF00093;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      repeat (5) begin
         #1;
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_imm", out_imm, 32'hFFFFFFFF);
         @(posedge clk);
      end
      #1;
      cnt_before = int'(dec_count);
      out_ready  = 1'b1;
      in_valid   = 1'b1;
      instr      = 32'h123452B7;
      #1;
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      chk("b2b_count", 32'(dec_count), 32'((cnt_before + 1) & 16'hFFFF));
      chk("b2b_issue_valid0", 32'(out_valid), 32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk); #1;
      chk("b2b_imm", out_imm, 32'h12345000);
      chk("b2b_fmt", 32'(out_fmt), 32'd5);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Asynchronous reset while an instruction is in ISSUE.
      in_valid = 1'b1;
      instr    = 32'h123452B7;
      @(posedge clk); #1;
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_out_imm", out_imm, 32'd0);
      chk("arst_out_fmt", 32'(out_fmt), 32'd0);
      chk("arst_out_ill", 32'(out_illegal), 32'd0);
      chk("arst_iu_imm", 32'(iu_imm), 32'd0);
      chk("arst_iu_src", 32'(iu_src), 32'd0);
      chk("arst_dec_count", 32'(dec_count), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("arst_dropped", 32'(out_valid), 32'd0);

      for (int i = 0; i < 5; i++)
         run_one("wrap", 32'h0080006F, 32'h00000008, 3'b110, 1'b0);
      chk("wrap_count2", 32'(dec_count2), 32'd1);
      chk("wrap_count16", 32'(dec_count), 32'd5);

      // Randomized traffic; the per-cycle compare process does the checking.
      for (int i = 0; i < 3000; i++) begin
         rnd       = $urandom;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 7) == 0) instr = $urandom;
         else instr = {rnd[31:7], ops[$urandom_range(0, 10)]};
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      held_imm = out_imm;
      chk("drain_idle", 32'(out_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
